uart_disp_ctrl: RTL and testbench
=================================

UART_DISP_CTRL -- requirements
Module: uart_disp_ctrl

Interface
REQ-001 SHALL have parameter SCROLL_TICKS, default 25000000, CLK cycles per scroll step (1 s at 25 MHz).
REQ-002 SHALL have parameter TIMEOUT_CLKS, default 21700, CLK cycles allowed between '!' prefix and command byte (10 byte times at 115200).
REQ-003 SHALL have port CLK  input  1  system clock; all state changes on rising edge.
REQ-004 SHALL have port RST  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port i_RX_DV  input  1  one-cycle strobe from the UART receiver: i_RX_Byte valid.
REQ-006 SHALL have port i_RX_Byte  input  8  received byte.
REQ-007 SHALL have port o_Disp_Byte  output  8  byte driven to the two hex seven-segment decoders ([7:4] digit 1, [3:0] digit 2).
REQ-008 SHALL have port o_Blank  output  1  1 = both displays dark.
REQ-009 SHALL have port o_Disp_Index  output  2  history slot currently shown (0 = newest).
REQ-010 SHALL have port o_Count  output  3  valid history entries, 0..4.
REQ-011 SHALL have port o_Hold, o_Scroll  output  1 each  current mode flags.
REQ-012 SHALL have port o_Err  output  1  one-cycle pulse on protocol error.

Function
REQ-013 SHALL hold a 4-entry byte history; a push shifts slot n into slot n+1, writes slot 0, discards slot 3; o_Count increments, saturating at 4.
REQ-014 SHALL implement FSM states DATA and CMD; registered state, single i_RX_DV processed per cycle.
REQ-015 In DATA: byte 0x21 ('!') SHALL go to CMD and clear timeout counter; any other byte SHALL be pushed.
REQ-016 In CMD, on i_RX_DV, SHALL decode then return to DATA: 0x48 'H' toggle hold; 0x42 'B' toggle blank; 0x53 'S' toggle scroll (entry: index 0, scroll timer cleared); 0x43 'C' clear history (all slots 0x00, count 0, index 0; hold/blank/scroll unchanged); 0x21 push literal 0x21; anything else pulse o_Err, no other effect.
REQ-017 In CMD, if timeout counter reaches TIMEOUT_CLKS-1 with no i_RX_DV, SHALL pulse o_Err and return to DATA; a byte arriving on that same cycle SHALL be decoded as a command and no error issued.
REQ-018 Not hold, not scroll: o_Disp_Index SHALL be 0 and o_Disp_Byte SHALL equal slot 0.
REQ-019 Scroll, not hold: scroll timer counts every cycle; at SCROLL_TICKS-1 it wraps to 0 and index advances; index wraps to 0 after o_Count-1; with o_Count 0 or 1, index stays 0.
REQ-020 Scroll and a data push in the same cycle: index SHALL reset to 0 and scroll timer clear.
REQ-021 Hold: o_Disp_Byte and o_Disp_Index SHALL freeze at value at entry; scroll timer stops; pushes and clears still update history and o_Count; on hold exit display resumes per REQ-018/019 next cycle.
REQ-022 o_Disp_Byte SHALL be registered: updates the cycle after the i_RX_DV cycle that changed it (1-cycle latency).
REQ-023 o_Blank SHALL not affect history, index or o_Disp_Byte value.
REQ-024 All outputs SHALL be registered; o_Err never high two consecutive cycles.

Reset
REQ-025 RST high SHALL immediately set: state DATA, history 0x00, o_Count 0, o_Disp_Byte 0x00, o_Disp_Index 0, o_Blank 0, o_Hold 0, o_Scroll 0, o_Err 0, all counters 0.
REQ-026 RST mid-command or mid-scroll SHALL abandon it; no o_Err on or after release.
REQ-027 First i_RX_DV accepted on first rising edge after RST deasserts.

Verification
REQ-028 Push 0x41,0x42,0x43 -> o_Disp_Byte 0x43 one cycle after each last strobe, o_Count 3.
REQ-029 Push 0x11..0x15, '!','S', SCROLL_TICKS=4 -> o_Disp_Byte sequence 0x15,0x14,0x13,0x12,0x15 every 4 cycles, index 0,1,2,3,0.
REQ-030 '!','H', push 0x77 -> o_Disp_Byte unchanged, o_Count +1; '!','H' -> 0x77 shown.
REQ-031 '!','Z' -> o_Err one pulse, state DATA; '!' then idle TIMEOUT_CLKS cycles -> o_Err one pulse; '!','!' -> 0x21 pushed.
REQ-032 '!','B' -> o_Blank 1, o_Disp_Byte keeps value; '!','C' -> o_Count 0, o_Disp_Byte 0x00.
REQ-033 RST asserted mid-scroll with hold set -> all outputs at REQ-025 values asynchronously, no o_Err after release.

Source files
------------

// File: rtl/uart_disp_ctrl_if.sv
// UART receive strobe plus display/status outputs of the
// history display controller.
interface uart_disp_ctrl_if;
   logic       i_RX_DV;
   logic [7:0] i_RX_Byte;
   logic [7:0] o_Disp_Byte;
   logic       o_Blank;
   logic [1:0] o_Disp_Index;
   logic [2:0] o_Count;
   logic       o_Hold;
   logic       o_Scroll;
   logic       o_Err;

   modport master (
      output i_RX_DV, i_RX_Byte,
      input  o_Disp_Byte, o_Blank, o_Disp_Index,
      input  o_Count, o_Hold, o_Scroll, o_Err
   );

   modport slave (
      input  i_RX_DV, i_RX_Byte,
      output o_Disp_Byte, o_Blank, o_Disp_Index,
      output o_Count, o_Hold, o_Scroll, o_Err
   );
endinterface

// File: rtl/uart_disp_ctrl.sv
// Four-entry UART byte history shown on two hex digits, with
// '!'-prefixed commands for hold, blank, scroll and clear.
module uart_disp_ctrl #(
   parameter int SCROLL_TICKS = 25000000,
   parameter int TIMEOUT_CLKS = 21700
) (
   input  logic            CLK,
   input  logic            RST,
   uart_disp_ctrl_if.slave bus
);
   localparam int SW = (SCROLL_TICKS > 1) ? $clog2(SCROLL_TICKS) : 1;
   localparam int TW = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;
   localparam logic [SW-1:0] SCR_LAST = SW'(SCROLL_TICKS - 1);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CLKS - 1);

   typedef enum logic {DATA, CMD} state_t;

   state_t        state, state_n;
   logic [7:0]    hist [4];
   logic [7:0]    hist_n [4];
   logic [2:0]    count, count_n;
   logic [1:0]    idx, idx_n;
   logic [7:0]    disp, disp_n;
   logic          blank, blank_n;
   logic          hold, hold_n;
   logic          scroll, scroll_n;
   logic          err, err_n;
   logic [TW-1:0] tmo, tmo_n;
   logic [SW-1:0] scr, scr_n;
   logic          push, clr, scr_on;

   always_comb begin
      state_n  = state;
      tmo_n    = tmo;
      blank_n  = blank;
      hold_n   = hold;
      scroll_n = scroll;
      err_n    = 1'b0;
      push     = 1'b0;
      clr      = 1'b0;
      scr_on   = 1'b0;
      unique case (state)
         DATA: begin
            if (bus.i_RX_DV) begin
               if (bus.i_RX_Byte == 8'h21) begin
                  state_n = CMD;
                  tmo_n   = '0;
               end else begin
                  push = 1'b1;
               end
            end
         end
         CMD: begin
            // A byte on the expiry cycle wins over the timeout.
            if (bus.i_RX_DV) begin
               state_n = DATA;
               case (bus.i_RX_Byte)
                  8'h48: hold_n  = ~hold;
                  8'h42: blank_n = ~blank;
                  8'h53: begin
                     scroll_n = ~scroll;
                     scr_on   = ~scroll;
                  end
                  8'h43: clr  = 1'b1;
                  8'h21: push = 1'b1;
                  default: err_n = 1'b1;
               endcase
            end else if (tmo == TMO_LAST) begin
               err_n   = 1'b1;
               state_n = DATA;
            end else begin
               tmo_n = tmo + TW'(1);
            end
         end
      endcase
   end

   always_comb begin
      hist_n  = hist;
      count_n = count;
      if (clr) begin
         for (int i = 0; i < 4; i++) hist_n[i] = 8'h00;
         count_n = 3'd0;
      end else if (push) begin
         hist_n[3] = hist[2];
         hist_n[2] = hist[1];
         hist_n[1] = hist[0];
         hist_n[0] = bus.i_RX_Byte;
         if (count != 3'd4) count_n = count + 3'd1;
      end
   end

   // While held, index, byte and scroll timer all freeze.
   always_comb begin
      idx_n  = idx;
      disp_n = disp;
      scr_n  = scr;
      if (!hold_n) begin
         if (!scroll_n) begin
            idx_n = 2'd0;
            scr_n = '0;
         end else if (scr_on || push) begin
            idx_n = 2'd0;
            scr_n = '0;
         end else if (scr == SCR_LAST) begin
            scr_n = '0;
            if (({1'b0, idx} + 3'd1) >= count_n) idx_n = 2'd0;
            else idx_n = idx + 2'd1;
         end else begin
            scr_n = scr + SW'(1);
            if ({1'b0, idx} >= count_n) idx_n = 2'd0;
         end
         disp_n = hist_n[idx_n];
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state  <= DATA;
         for (int i = 0; i < 4; i++) hist[i] <= 8'h00;
         count  <= 3'd0;
         idx    <= 2'd0;
         disp   <= 8'h00;
         blank  <= 1'b0;
         hold   <= 1'b0;
         scroll <= 1'b0;
         err    <= 1'b0;
         tmo    <= '0;
         scr    <= '0;
      end else begin
         state  <= state_n;
         for (int i = 0; i < 4; i++) hist[i] <= hist_n[i];
         count  <= count_n;
         idx    <= idx_n;
         disp   <= disp_n;
         blank  <= blank_n;
         hold   <= hold_n;
         scroll <= scroll_n;
         err    <= err_n;
         tmo    <= tmo_n;
         scr    <= scr_n;
      end
   end

   assign bus.o_Disp_Byte  = disp;
   assign bus.o_Blank      = blank;
   assign bus.o_Disp_Index = idx;
   assign bus.o_Count      = count;
   assign bus.o_Hold       = hold;
   assign bus.o_Scroll     = scroll;
   assign bus.o_Err        = err;
endmodule

// File: tb/tb_uart_disp_ctrl.sv
// Bench for uart_disp_ctrl: vector table, directed corner
// sequences and a random run against a queue-based model.
module tb_uart_disp_ctrl;
   localparam int ST = 4;
   localparam int TO = 8;

   logic CLK;
   logic RST;
   int   checks;
   int   failures;

   uart_disp_ctrl_if bus ();

   uart_disp_ctrl #(
      .SCROLL_TICKS(ST),
      .TIMEOUT_CLKS(TO)
   ) dut (
      .CLK(CLK),
      .RST(RST),
      .bus(bus)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Reference model: history as a queue, newest at the front.
   logic [7:0] hq[$];
   bit         m_cmd, m_hold, m_blank, m_scroll, m_err;
   int         m_tmo, m_tick, m_idx;
   logic [7:0] m_disp;

   function automatic logic [7:0] slot(input int i);
      return (i < hq.size()) ? hq[i] : 8'h00;
   endfunction

   task automatic model_reset();
      hq.delete();
      m_cmd = 0; m_hold = 0; m_blank = 0; m_scroll = 0; m_err = 0;
      m_tmo = 0; m_tick = 0; m_idx = 0; m_disp = 8'h00;
   endtask

   task automatic model_step(input bit dv, input logic [7:0] b);
      bit pushed;
      bit entered;
      pushed  = 0;
      entered = 0;
      m_err   = 0;
      if (!m_cmd) begin
         if (dv) begin
            if (b == 8'h21) begin
               m_cmd = 1;
               m_tmo = 0;
            end else begin
               pushed = 1;
            end
         end
      end else if (dv) begin
         m_cmd = 0;
         case (b)
            8'h48: m_hold = !m_hold;
            8'h42: m_blank = !m_blank;
            8'h53: begin m_scroll = !m_scroll; entered = m_scroll; end
            8'h43: hq.delete();
            8'h21: pushed = 1;
            default: m_err = 1;
         endcase
      end else if (m_tmo == TO - 1) begin
         m_err = 1;
         m_cmd = 0;
      end else begin
         m_tmo++;
      end
      if (pushed) begin
         hq.push_front(b);
         if (hq.size() > 4) void'(hq.pop_back());
      end
      if (!m_hold) begin
         if (!m_scroll || entered || pushed) begin
            m_idx  = 0;
            m_tick = 0;
         end else begin
            m_tick++;
            if (m_tick == ST) begin
               m_tick = 0;
               m_idx  = (m_idx + 1 >= hq.size()) ? 0 : m_idx + 1;
            end else if (m_idx >= hq.size()) begin
               m_idx = 0;
            end
         end
         m_disp = slot(m_idx);
      end
   endtask

   function automatic logic [16:0] act_b();
      return {bus.o_Disp_Byte, bus.o_Blank, bus.o_Disp_Index,
              bus.o_Count, bus.o_Hold, bus.o_Scroll, bus.o_Err};
   endfunction

   function automatic logic [16:0] exp_b();
      logic [1:0] i2;
      logic [2:0] c3;
      i2 = 2'(m_idx);
      c3 = 3'(hq.size());
      return {m_disp, m_blank, i2, c3, m_hold, m_scroll, m_err};
   endfunction

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick(input bit dv, input logic [7:0] b);
      bus.i_RX_DV   = dv;
      bus.i_RX_Byte = b;
      @(posedge CLK);
      model_step(dv, b);
      #1;
   endtask

   typedef struct {
      bit         dv;
      logic [7:0] b;
      logic [7:0] disp;
      logic [2:0] cnt;
      bit         blank;
      bit         hold;
      bit         err;
   } vec_t;

   vec_t tbl[19];

   initial begin
      checks   = 0;
      failures = 0;
      tbl[0]  = '{1, 8'h41, 8'h41, 3'd1, 0, 0, 0};
      tbl[1]  = '{1, 8'h42, 8'h42, 3'd2, 0, 0, 0};
      tbl[2]  = '{1, 8'h43, 8'h43, 3'd3, 0, 0, 0};
      tbl[3]  = '{1, 8'h21, 8'h43, 3'd3, 0, 0, 0};
      tbl[4]  = '{1, 8'h48, 8'h43, 3'd3, 0, 1, 0};
      tbl[5]  = '{1, 8'h77, 8'h43, 3'd4, 0, 1, 0};
      tbl[6]  = '{1, 8'h21, 8'h43, 3'd4, 0, 1, 0};
      tbl[7]  = '{1, 8'h48, 8'h77, 3'd4, 0, 0, 0};
      tbl[8]  = '{1, 8'h21, 8'h77, 3'd4, 0, 0, 0};
      tbl[9]  = '{1, 8'h5A, 8'h77, 3'd4, 0, 0, 1};
      tbl[10] = '{0, 8'h00, 8'h77, 3'd4, 0, 0, 0};
      tbl[11] = '{1, 8'h21, 8'h77, 3'd4, 0, 0, 0};
      tbl[12] = '{1, 8'h21, 8'h21, 3'd4, 0, 0, 0};
      tbl[13] = '{1, 8'h21, 8'h21, 3'd4, 0, 0, 0};
      tbl[14] = '{1, 8'h42, 8'h21, 3'd4, 1, 0, 0};
      tbl[15] = '{1, 8'h21, 8'h21, 3'd4, 1, 0, 0};
      tbl[16] = '{1, 8'h43, 8'h00, 3'd0, 1, 0, 0};
      tbl[17] = '{1, 8'h21, 8'h00, 3'd0, 1, 0, 0};
      tbl[18] = '{1, 8'h42, 8'h00, 3'd0, 0, 0, 0};

      RST = 1'b1;
      bus.i_RX_DV   = 1'b0;
      bus.i_RX_Byte = 8'h00;
      model_reset();
      #12;
      chk("reset_state", 32'(act_b()), 32'd0);
      RST = 1'b0;

      foreach (tbl[i]) begin
         tick(tbl[i].dv, tbl[i].b);
         chk($sformatf("vec%0d", i), 32'(act_b()),
             32'({tbl[i].disp, tbl[i].blank, 2'd0, tbl[i].cnt,
                  tbl[i].hold, 1'b0, tbl[i].err}));
      end

      // Timeout: error exactly TO cycles after the prefix.
      tick(1, 8'h21);
      for (int k = 1; k <= TO + 1; k++) begin
         tick(0, 8'h00);
         chk($sformatf("timeout_k%0d", k), 32'(bus.o_Err),
             32'(k == TO));
      end
      tick(1, 8'h5A);
      chk("after_timeout_data", 32'({bus.o_Disp_Byte, bus.o_Count,
          bus.o_Err}), 32'({8'h5A, 3'd1, 1'b0}));

      // Byte on the expiry cycle is a command, not an error.
      tick(1, 8'h21);
      repeat (TO - 1) tick(0, 8'h00);
      tick(1, 8'h48);
      chk("expiry_cmd", 32'({bus.o_Hold, bus.o_Err}), 32'b10);
      tick(0, 8'h00);
      chk("expiry_no_err", 32'(bus.o_Err), 32'd0);
      tick(1, 8'h21);
      tick(1, 8'h48);
      chk("hold_off", 32'(bus.o_Hold), 32'd0);

      // Scroll walk through four entries.
      for (int v = 8'h11; v <= 8'h15; v++) tick(1, 8'(v));
      chk("scroll_fill", 32'({bus.o_Disp_Byte, bus.o_Count}),
          32'({8'h15, 3'd4}));
      tick(1, 8'h21);
      tick(1, 8'h53);
      chk("scroll_entry", 32'({bus.o_Disp_Byte, bus.o_Disp_Index,
          bus.o_Scroll}), 32'({8'h15, 2'd0, 1'b1}));
      for (int k = 1; k <= 16; k++) begin
         logic [1:0] ei;
         tick(0, 8'h00);
         ei = 2'((k / ST) % 4);
         chk($sformatf("scroll_k%0d", k),
             32'({bus.o_Disp_Byte, bus.o_Disp_Index}),
             32'({8'h15 - 8'(ei), ei}));
      end
      repeat (5) tick(0, 8'h00);
      chk("scroll_mid", 32'({bus.o_Disp_Byte, bus.o_Disp_Index}),
          32'({8'h14, 2'd1}));
      tick(1, 8'h99);
      chk("scroll_push", 32'({bus.o_Disp_Byte, bus.o_Disp_Index}),
          32'({8'h99, 2'd0}));
      repeat (3) tick(0, 8'h00);
      chk("scroll_push_hold0", 32'(bus.o_Disp_Byte), 32'h99);
      tick(0, 8'h00);
      chk("scroll_push_step", 32'({bus.o_Disp_Byte, bus.o_Disp_Index}),
          32'({8'h15, 2'd1}));

      // Hold while scrolling freezes the shown slot.
      tick(1, 8'h21);
      tick(1, 8'h48);
      repeat (10) tick(0, 8'h00);
      chk("scroll_hold", 32'({bus.o_Disp_Byte, bus.o_Disp_Index,
          bus.o_Hold, bus.o_Scroll}), 32'({8'h15, 2'd1, 2'b11}));

      // Asynchronous reset mid-command, mid-scroll, held.
      tick(1, 8'h21);
      RST = 1'b1;
      #1;
      chk("async_reset", 32'(act_b()), 32'd0);
      bus.i_RX_DV = 1'b0;
      @(negedge CLK);
      @(negedge CLK);
      RST = 1'b0;
      model_reset();
      for (int k = 0; k < TO + 4; k++) begin
         tick(0, 8'h00);
         chk($sformatf("post_reset_k%0d", k), 32'(act_b()), 32'd0);
      end

      // Random traffic against the model.
      for (int n = 0; n < 3000; n++) begin
         int sel;
         logic [7:0] b;
         bit dv;
         sel = $urandom_range(0, 11);
         case (sel)
            0, 1, 2: b = 8'h21;
            3: b = 8'h48;
            4: b = 8'h42;
            5: b = 8'h53;
            6: b = ($urandom_range(0, 3) == 0) ? 8'h43 : 8'h21;
            7: b = 8'h5A;
            default: b = 8'($urandom);
         endcase
         dv = ($urandom_range(0, 1) == 1);
         if ($urandom_range(0, 39) == 0) begin
            repeat (TO + 2) begin
               tick(0, 8'h00);
               chk("rand_idle", 32'(act_b()), 32'(exp_b()));
            end
         end
         tick(dv, b);
         chk("rand", 32'(act_b()), 32'(exp_b()));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
